// File: rtl/dcache_sram_nway.sv
// N-way set-associative dcache storage: tag/data/valid/dirty per line, true-LRU ages per set,
// combinational lookup with victim presentation, and a one-set-per-cycle invalidate-all walk.
module dcache_sram_nway #(
  parameter int WAYS   = 4,
  parameter int SETS   = 16,
  parameter int TAG_W  = 23,
  parameter int LINE_W = 256,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic              dirty_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              inv_all_i,
  output logic              hit_o,
  output logic [WAY_W-1:0]  way_o,
  output logic [TAG_W+1:0]  tag_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o
);

  typedef enum logic {IDLE, WALK} state_t;

  state_t            state_reg;
  logic [IDX_W-1:0]  cnt_reg;

  logic              valid_reg [SETS][WAYS];
  logic              dirty_reg [SETS][WAYS];
  logic [TAG_W-1:0]  tag_reg   [SETS][WAYS];
  logic [LINE_W-1:0] data_reg  [SETS][WAYS];
  logic [WAY_W-1:0]  age_reg   [SETS][WAYS];

  logic [WAYS-1:0]   match;
  logic [WAYS-1:0]   invalid;
  logic [WAYS-1:0]   is_lru;

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    assign match[gi]   = valid_reg[addr_i][gi] && (tag_reg[addr_i][gi] == tag_i);
    assign invalid[gi] = !valid_reg[addr_i][gi];
    assign is_lru[gi]  = (age_reg[addr_i][gi] == WAY_W'(WAYS - 1));
  end

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] lru_way;
  logic [WAY_W-1:0] sel_way;
  logic [WAY_W-1:0] sel_age;

  // Descending scans so the lowest matching index is the one left standing.
  always_comb begin
    hit     = |match;
    hit_way = '0;
    inv_way = '0;
    lru_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (match[w])   hit_way = WAY_W'(w);
      if (invalid[w]) inv_way = WAY_W'(w);
      if (is_lru[w])  lru_way = WAY_W'(w);
    end
    if (hit)
      sel_way = hit_way;
    else if (|invalid)
      sel_way = inv_way;
    else
      sel_way = lru_way;
    sel_age = age_reg[addr_i][sel_way];
  end

  logic busy;
  logic active;
  logic do_access;
  logic do_promote;

  assign busy       = (state_reg == WALK);
  assign active     = enable_i && !busy;
  assign do_access  = active && !inv_all_i;
  assign do_promote = do_access && (write_i || hit);

  assign busy_o = busy;
  assign hit_o  = active && hit;
  assign way_o  = active ? sel_way : '0;
  assign tag_o  = active ? {valid_reg[addr_i][sel_way], dirty_reg[addr_i][sel_way],
                            tag_reg[addr_i][sel_way]} : '0;
  assign data_o = active ? data_reg[addr_i][sel_way] : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_reg[s][w] <= 1'b0;
          dirty_reg[s][w] <= 1'b0;
          tag_reg[s][w]   <= '0;
          data_reg[s][w]  <= '0;
          age_reg[s][w]   <= WAY_W'(w);
        end
      end
    end else if (state_reg == WALK) begin
      for (int w = 0; w < WAYS; w++) begin
        valid_reg[cnt_reg][w] <= 1'b0;
        dirty_reg[cnt_reg][w] <= 1'b0;
        age_reg[cnt_reg][w]   <= WAY_W'(w);
      end
      cnt_reg <= cnt_reg + 1'b1;
      if (cnt_reg == IDX_W'(SETS - 1))
        state_reg <= IDLE;
    end else if (inv_all_i) begin
      state_reg <= WALK;
      cnt_reg   <= '0;
    end else begin
      // On a write hit the tag is unchanged, so rewriting tag_i is harmless.
      if (do_access && write_i) begin
        valid_reg[addr_i][sel_way] <= 1'b1;
        dirty_reg[addr_i][sel_way] <= dirty_i;
        tag_reg[addr_i][sel_way]   <= tag_i;
        data_reg[addr_i][sel_way]  <= data_i;
      end
      if (do_promote) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == sel_way)
            age_reg[addr_i][w] <= '0;
          else if (age_reg[addr_i][w] < sel_age)
            age_reg[addr_i][w] <= age_reg[addr_i][w] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dcache_sram_nway.sv
// Randomised and directed bench for dcache_sram_nway against a recency-list cache model.
module tb_dcache_sram_nway;

  localparam int WAYS   = 4;
  localparam int SETS   = 16;
  localparam int TAG_W  = 23;
  localparam int LINE_W = 256;
  localparam int IDX_W  = 4;
  localparam int WAY_W  = 2;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              enable_i = 1'b0;
  logic              write_i = 1'b0;
  logic              dirty_i = 1'b0;
  logic [IDX_W-1:0]  addr_i = '0;
  logic [TAG_W-1:0]  tag_i = '0;
  logic [LINE_W-1:0] data_i = '0;
  logic              inv_all_i = 1'b0;
  logic              hit_o;
  logic [WAY_W-1:0]  way_o;
  logic [TAG_W+1:0]  tag_o;
  logic [LINE_W-1:0] data_o;
  logic              busy_o;

  dcache_sram_nway #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .write_i(write_i),
    .dirty_i(dirty_i), .addr_i(addr_i), .tag_i(tag_i), .data_i(data_i),
    .inv_all_i(inv_all_i), .hit_o(hit_o), .way_o(way_o), .tag_o(tag_o),
    .data_o(data_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: per set, a recency list of way numbers (index 0 = most recent).
  bit                m_valid [SETS][WAYS];
  bit                m_dirty [SETS][WAYS];
  logic [TAG_W-1:0]  m_tag   [SETS][WAYS];
  logic [LINE_W-1:0] m_data  [SETS][WAYS];
  int                m_order [SETS][WAYS];
  int                m_busy_cnt;

  logic              r_hit;
  logic [WAY_W-1:0]  r_way;
  logic [TAG_W+1:0]  r_tag;
  logic [LINE_W-1:0] r_data;
  logic              r_busy;

  task automatic check(input string name, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic int m_hit_way(input int s, input logic [TAG_W-1:0] t);
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) return w;
    return -1;
  endfunction

  function automatic int m_victim(input int s);
    for (int w = 0; w < WAYS; w++)
      if (!m_valid[s][w]) return w;
    return m_order[s][WAYS-1];
  endfunction

  task automatic m_touch(input int s, input int w);
    int p = 0;
    for (int i = 0; i < WAYS; i++)
      if (m_order[s][i] == w) p = i;
    for (int i = p; i > 0; i--)
      m_order[s][i] = m_order[s][i-1];
    m_order[s][0] = w;
  endtask

  task automatic m_clear(input bit full);
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
        m_order[s][w] = w;
        if (full) begin
          m_tag[s][w]  = '0;
          m_data[s][w] = '0;
        end
      end
  endtask

  task automatic cycle(input bit en, input bit wr, input bit d, input bit inv,
                       input int s, input logic [TAG_W-1:0] t, input logic [LINE_W-1:0] dat);
    int hw, sel;
    logic              e_hit;
    logic [WAY_W-1:0]  e_way;
    logic [TAG_W+1:0]  e_tag;
    logic [LINE_W-1:0] e_data;
    @(negedge clk_i);
    enable_i = en; write_i = wr; dirty_i = d; inv_all_i = inv;
    addr_i = IDX_W'(s); tag_i = t; data_i = dat;
    #1;
    hw  = m_hit_way(s, t);
    sel = (hw >= 0) ? hw : m_victim(s);
    if (!en || m_busy_cnt > 0) begin
      e_hit = 0; e_way = '0; e_tag = '0; e_data = '0;
    end else begin
      e_hit  = (hw >= 0);
      e_way  = WAY_W'(sel);
      e_tag  = {m_valid[s][sel], m_dirty[s][sel], m_tag[s][sel]};
      e_data = m_data[s][sel];
    end
    r_hit = hit_o; r_way = way_o; r_tag = tag_o; r_data = data_o; r_busy = busy_o;
    check("hit",  LINE_W'(hit_o),  LINE_W'(e_hit));
    check("way",  LINE_W'(way_o),  LINE_W'(e_way));
    check("tag",  LINE_W'(tag_o),  LINE_W'(e_tag));
    check("data", data_o, e_data);
    check("busy", LINE_W'(busy_o), LINE_W'(m_busy_cnt > 0));
    @(posedge clk_i);
    if (m_busy_cnt > 0) begin
      m_busy_cnt--;
    end else if (inv) begin
      m_clear(0);
      m_busy_cnt = SETS;
    end else if (en) begin
      if (wr) begin
        m_valid[s][sel] = 1;
        m_dirty[s][sel] = d;
        m_tag[s][sel]   = t;
        m_data[s][sel]  = dat;
        m_touch(s, sel);
      end else if (hw >= 0) begin
        m_touch(s, hw);
      end
    end
  endtask

  task automatic lookup(input int s, input int t);
    cycle(1, 0, 0, 0, s, TAG_W'(t), '0);
  endtask

  task automatic wr_line(input int s, input int t, input logic [LINE_W-1:0] dat, input bit d);
    cycle(1, 1, d, 0, s, TAG_W'(t), dat);
  endtask

  function automatic logic [LINE_W-1:0] rnd_line();
    logic [LINE_W-1:0] v;
    for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  initial begin
    logic [LINE_W-1:0] line_a, line_b;
    int busy_seen;
    m_clear(1);
    m_busy_cnt = 0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_busy", LINE_W'(busy_o), '0);
    check("rst_hit",  LINE_W'(hit_o),  '0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Empty cache lookup
    lookup(3, 'h1A);
    check("tp1_hit", LINE_W'(r_hit), '0);
    check("tp1_way", LINE_W'(r_way), '0);
    check("tp1_tag", LINE_W'(r_tag), '0);

    // Fill and LRU victim after a touch
    for (int i = 0; i < 4; i++) wr_line(5, 'h10 + i, rnd_line(), 0);
    lookup(5, 'h10);
    check("tp2_hit", LINE_W'(r_hit), LINE_W'(1));
    check("tp2_way", LINE_W'(r_way), '0);
    lookup(5, 'h20);
    check("tp2_lru", LINE_W'(r_way), LINE_W'(1));

    // Touch order 3,1,0 leaves way 2 as LRU
    for (int i = 0; i < 4; i++) wr_line(2, 'h30 + i, rnd_line(), 0);
    lookup(2, 'h33); lookup(2, 'h31); lookup(2, 'h30);
    wr_line(2, 'h77, rnd_line(), 1);
    check("tp3_victim", LINE_W'(r_way), LINE_W'(2));
    lookup(2, 'h77);
    check("tp3_hit", LINE_W'(r_hit), LINE_W'(1));
    check("tp3_way", LINE_W'(r_way), LINE_W'(2));
    check("tp3_tag", LINE_W'(r_tag), LINE_W'({2'b11, 23'h77}));

    // Dirty write hit then eviction shows victim contents
    line_a = rnd_line();
    line_b = rnd_line();
    wr_line(7, 'h40, line_a, 0);
    wr_line(7, 'h40, line_b, 1);
    for (int i = 1; i < 4; i++) wr_line(7, 'h40 + i, rnd_line(), 0);
    lookup(7, 'h99);
    check("tp4_way",  LINE_W'(r_way), '0);
    check("tp4_tag",  LINE_W'(r_tag), LINE_W'({2'b11, 23'h40}));
    check("tp4_data", r_data, line_b);

    // Invalidate-all with accesses attempted while busy
    cycle(0, 0, 0, 1, 0, '0, '0);
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(i < 16, 1, 1, i == 3, 5, TAG_W'('h55), rnd_line());
      if (r_busy) busy_seen++;
      if (i < 16) check("busy_hit", LINE_W'(r_hit), '0);
    end
    check("busy_len", LINE_W'(busy_seen), LINE_W'(16));
    lookup(5, 'h55);
    check("inv_nowrite", LINE_W'(r_hit), '0);
    lookup(5, 'h10);
    check("inv_miss", LINE_W'(r_hit), '0);
    check("inv_way0", LINE_W'(r_way), '0);
    lookup(2, 'h77);
    check("inv_miss2", LINE_W'(r_hit), '0);

    // Random traffic
    for (int i = 0; i < 600; i++)
      cycle(($urandom % 4) != 0, $urandom % 2, $urandom % 2, ($urandom % 150) == 0,
            (i < 300) ? int'($urandom % 4) : int'($urandom % SETS), TAG_W'($urandom % 6), rnd_line());
    while (m_busy_cnt > 0) cycle(0, 0, 0, 0, 0, '0, '0);
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) wr_line(s, s + 8 * w, rnd_line(), 1);

    // Reset in the middle of a walk
    cycle(0, 0, 0, 1, 0, '0, '0);
    repeat (7) cycle(0, 0, 0, 0, 0, '0, '0);
    #3 rst_i = 1'b1;
    #1 check("rst_walk_busy", LINE_W'(busy_o), '0);
    #1 rst_i = 1'b0;
    m_clear(1);
    m_busy_cnt = 0;
    for (int s = 0; s < SETS; s++) begin
      lookup(s, s + 8 * (s % 4));
      check("rst_all_inv", LINE_W'(r_hit), '0);
    end
    cycle(0, 0, 0, 1, 0, '0, '0);
    cycle(0, 0, 0, 0, 0, '0, '0);
    check("rst_new_inv", LINE_W'(r_busy), LINE_W'(1));
    while (m_busy_cnt > 0) cycle(0, 0, 0, 0, 0, '0, '0);
    lookup(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
